// File: rtl/qdiv_if.sv
// Handshake bundle for the qdiv divider: operand request and result response.
// Latency: none, wiring only.
// Backpressure: o_ready/i_valid on the request side, o_valid/i_ready on the result side.
interface qdiv_if #(parameter int DWIDTH = 8);
    logic                       i_valid;
    logic                       o_ready;
    logic signed [2*DWIDTH-1:0] i_dividend;
    logic signed [DWIDTH-1:0]   i_divisor;
    logic                       o_valid;
    logic                       i_ready;
    logic signed [DWIDTH-1:0]   o_quotient;
    logic signed [DWIDTH-1:0]   o_remainder;
    logic                       o_ovf;
    logic                       o_div0;

    // Divider side
    modport slave (
        input  i_valid, i_dividend, i_divisor, i_ready,
        output o_ready, o_valid, o_quotient, o_remainder, o_ovf, o_div0
    );

    // Requester / consumer side
    modport master (
        output i_valid, i_dividend, i_divisor, i_ready,
        input  o_ready, o_valid, o_quotient, o_remainder, o_ovf, o_div0
    );
endinterface

// File: rtl/qdiv.sv
// Signed restoring divider: 2*DWIDTH dividend / DWIDTH divisor -> saturated quotient + remainder.
// Latency: 2*DWIDTH+1 edges from accept to o_valid; 1 edge for divide-by-zero.
// Backpressure: accepts only when idle; result held in DONE until i_ready.
module qdiv #(
    parameter int DWIDTH = 8
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    qdiv_if.slave bus
);
    localparam int DW2 = 2 * DWIDTH;
    localparam int CW  = $clog2(DW2 + 1);

    localparam logic [DW2-1:0]    QPOS_LIM = DW2'((1 << (DWIDTH - 1)) - 1);
    localparam logic [DW2-1:0]    QNEG_LIM = DW2'(1 << (DWIDTH - 1));
    localparam logic [DWIDTH-1:0] Q_MAX    = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] Q_MIN    = {1'b1, {(DWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [DW2:0]      dvd_mag;   // one spare bit so |-2^(2W-1)| is exact
    logic [DWIDTH:0]   dsr_mag;
    logic [DWIDTH:0]   prem;
    logic [DW2-1:0]    q_mag;
    logic              dvd_neg, dsr_neg, is_div0;
    logic [DWIDTH-1:0] q_out, r_out;
    logic              ovf_out, div0_out;

    logic              accept;
    logic [DW2:0]      dvd_ext;
    logic [DWIDTH:0]   dsr_ext;
    logic [DW2:0]      dvd_abs;
    logic [DWIDTH:0]   dsr_abs;
    logic [DWIDTH:0]   trial, diff;
    logic              ge;
    logic [DWIDTH-1:0] q_fin, r_fin;
    logic              ovf_fin;

    assign accept          = bus.i_valid && (state == IDLE);
    assign bus.o_ready     = (state == IDLE);
    assign bus.o_valid     = (state == DONE);
    assign bus.o_quotient  = q_out;
    assign bus.o_remainder = r_out;
    assign bus.o_ovf       = ovf_out;
    assign bus.o_div0      = div0_out;

    // Operand magnitudes, sign-extended by one bit before negation
    assign dvd_ext = {bus.i_dividend[DW2-1], bus.i_dividend};
    assign dsr_ext = {bus.i_divisor[DWIDTH-1], bus.i_divisor};
    assign dvd_abs = dvd_ext[DW2] ? -dvd_ext : dvd_ext;
    assign dsr_abs = dsr_ext[DWIDTH] ? -dsr_ext : dsr_ext;

    // One restoring step: bring in the next dividend bit and trial-subtract
    assign trial = {prem[DWIDTH-1:0], dvd_mag[DW2-1]};
    assign ge    = (trial >= dsr_mag);
    assign diff  = trial - dsr_mag;

    // Sign restoration and saturation of the finished magnitudes
    always_comb begin
        q_fin   = q_mag[DWIDTH-1:0];
        ovf_fin = 1'b0;
        r_fin   = dvd_neg ? -prem[DWIDTH-1:0] : prem[DWIDTH-1:0];
        if (is_div0) begin
            q_fin = dvd_neg ? Q_MIN : Q_MAX;
            r_fin = '0;
        end else if (!(dvd_neg ^ dsr_neg)) begin
            if (q_mag > QPOS_LIM) begin
                q_fin   = Q_MAX;
                ovf_fin = 1'b1;
            end
        end else if (q_mag > QNEG_LIM) begin
            q_fin   = Q_MIN;
            ovf_fin = 1'b1;
        end else begin
            q_fin = -q_mag[DWIDTH-1:0];
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: divide-by-zero also passes through one CALC edge (cnt=0) to load results
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)      state_nxt = CALC;
            CALC:    if (cnt == '0)   state_nxt = DONE;
            DONE:    if (bus.i_ready) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt      <= '0;
            dvd_mag  <= '0;
            dsr_mag  <= '0;
            prem     <= '0;
            q_mag    <= '0;
            dvd_neg  <= 1'b0;
            dsr_neg  <= 1'b0;
            is_div0  <= 1'b0;
            q_out    <= '0;
            r_out    <= '0;
            ovf_out  <= 1'b0;
            div0_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    dvd_neg <= bus.i_dividend[DW2-1];
                    dsr_neg <= bus.i_divisor[DWIDTH-1];
                    dvd_mag <= dvd_abs;
                    dsr_mag <= dsr_abs;
                    prem    <= '0;
                    q_mag   <= '0;
                    is_div0 <= (bus.i_divisor == '0);
                    cnt     <= (bus.i_divisor == '0) ? '0 : CW'(DW2);
                end
                CALC: if (cnt != '0) begin
                    prem    <= ge ? diff : trial;
                    q_mag   <= {q_mag[DW2-2:0], ge};
                    dvd_mag <= {dvd_mag[DW2-1:0], 1'b0};
                    cnt     <= cnt - CW'(1);
                end else begin
                    q_out    <= q_fin;
                    r_out    <= r_fin;
                    ovf_out  <= ovf_fin;
                    div0_out <= is_div0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_qdiv.sv
// Scoreboard bench for qdiv: driver pushes model results, monitor pops on o_valid.
// Checks values, fixed latency, backpressure hold, release timing and async reset.
// Consumer i_ready is randomly or deliberately held low by the monitor.
module tb_qdiv;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   force_bp = 0;

    typedef struct {
        int q; int r; int ovf; int div0; int lat; int t;
    } exp_t;
    exp_t sb[$];

    qdiv_if #(.DWIDTH(8)) bus();

    qdiv #(.DWIDTH(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division (truncates toward zero), then clamp
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int qq;
        e.ovf = 0; e.div0 = 0; e.t = 0;
        if (b == 0) begin
            e.q = (a >= 0) ? 127 : -128;
            e.r = 0;
            e.div0 = 1;
            e.lat = 1;
        end else begin
            qq  = a / b;
            e.r = a % b;
            e.lat = 17;
            if (qq > 127)       begin e.q = 127;  e.ovf = 1; end
            else if (qq < -128) begin e.q = -128; e.ovf = 1; end
            else                e.q = qq;
        end
        return e;
    endfunction

    task automatic do_op(input int a, input int b);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_timeout", 0, 1);
        bus.i_valid    = 1'b1;
        bus.i_dividend = 16'(a);
        bus.i_divisor  = 8'(b);
        @(posedge clk);
        #1;
        e   = model(a, b);
        e.t = cyc;
        sb.push_back(e);
        @(negedge clk);
        bus.i_valid    = 1'b0;
        bus.i_dividend = 16'($urandom);
        bus.i_divisor  = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.o_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 0, 1);
        @(negedge clk);
    endtask

    // Monitor: compare on each new result, check hold stability, drive i_ready
    initial begin
        int   hold, hq, hr, hovf, hdiv0;
        logic prev_valid, chk_rel;
        exp_t e;
        hold = 0; hq = 0; hr = 0; hovf = 0; hdiv0 = 0;
        prev_valid = 1'b0;
        chk_rel = 1'b0;
        bus.i_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid  = 1'b0;
                chk_rel     = 1'b0;
                bus.i_ready = 1'b0;
            end else begin
                if (chk_rel) begin
                    chk("release_valid", int'(bus.o_valid), 0);
                    chk("release_ready", int'(bus.o_ready), 1);
                    chk_rel = 1'b0;
                end
                if (bus.o_valid) begin
                    chk("busy_ready", int'(bus.o_ready), 0);
                    if (!prev_valid) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_result", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            chk("quotient",  int'(bus.o_quotient),  e.q);
                            chk("remainder", int'(bus.o_remainder), e.r);
                            chk("ovf",       int'(bus.o_ovf),       e.ovf);
                            chk("div0",      int'(bus.o_div0),      e.div0);
                            chk("latency",   cyc - e.t,             e.lat);
                        end
                        hq = int'(bus.o_quotient); hr = int'(bus.o_remainder);
                        hovf = int'(bus.o_ovf);    hdiv0 = int'(bus.o_div0);
                        if (force_bp > 0) begin
                            hold = force_bp;
                            force_bp = 0;
                        end else begin
                            hold = int'($urandom_range(0, 2));
                        end
                    end else begin
                        chk("hold_q",    int'(bus.o_quotient),  hq);
                        chk("hold_r",    int'(bus.o_remainder), hr);
                        chk("hold_ovf",  int'(bus.o_ovf),       hovf);
                        chk("hold_div0", int'(bus.o_div0),      hdiv0);
                    end
                    if (hold > 0) begin
                        bus.i_ready = 1'b0;
                        hold--;
                    end else begin
                        bus.i_ready = 1'b1;
                        chk_rel = 1'b1;
                    end
                end else begin
                    bus.i_ready = 1'b0;
                end
                prev_valid = bus.o_valid;
            end
        end
    end

    int da [11] = '{1000, -100, 100, -100, 1024, -1024, -32768, 16384, 32767, 500, -5};
    int db [11] = '{  10,    7,  -7,   -7,    8,     8,     -1,  -128,     1,   0,  0};

    initial begin
        int a, b, n;
        rst_n = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_dividend = '0;
        bus.i_divisor = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ready", int'(bus.o_ready),     1);
        chk("rst_valid", int'(bus.o_valid),     0);
        chk("rst_q",     int'(bus.o_quotient),  0);
        chk("rst_r",     int'(bus.o_remainder), 0);
        chk("rst_ovf",   int'(bus.o_ovf),       0);
        chk("rst_div0",  int'(bus.o_div0),      0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) do_op(da[i], db[i]);
        drain();

        // Backpressure: hold result 5 cycles while poking the request side
        force_bp = 5;
        do_op(300, 7);
        n = 0;
        while (!bus.o_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("bp_valid_timeout", 0, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.i_valid    = 1'b1;
            bus.i_dividend = 16'($urandom);
            bus.i_divisor  = 8'($urandom);
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        drain();

        // Back-to-back random operations
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) a = int'($urandom_range(0, 2000)) - 1000;
            else                          a = int'($signed(16'($urandom)));
            b = int'($signed(8'($urandom)));
            if ($urandom_range(0, 15) == 0) b = 0;
            do_op(a, b);
        end
        drain();

        // Asynchronous reset in the middle of an iteration
        do_op(-100, 7);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(bus.o_valid),     0);
        chk("midrst_ready", int'(bus.o_ready),     1);
        chk("midrst_q",     int'(bus.o_quotient),  0);
        chk("midrst_r",     int'(bus.o_remainder), 0);
        chk("midrst_ovf",   int'(bus.o_ovf),       0);
        chk("midrst_div0",  int'(bus.o_div0),      0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1000, 10);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
